// File: rtl/dirty_flush_walker.sv
// rtl/dirty_flush_walker.sv - dirty-bit flush walker with writeback handshake; optional clear via DIRTY_FLUSH_CLEAR_EN
module dirty_flush_walker #(
    parameter int NUM_SETS = 128,
    parameter int ADDR_W   = 7
) (
    input  logic              CLKA,
    input  logic              RST_N,
    input  logic              FLUSH_REQ,
    output logic              FLUSH_BUSY,
    output logic              FLUSH_DONE,
    output logic              RF_EN,
    output logic              RF_WE,
    output logic              RF_DIN,
    output logic [ADDR_W-1:0] RF_ADDR,
    input  logic              RF_DOUT,
    output logic              WB_VALID,
    input  logic              WB_READY,
    output logic [ADDR_W-1:0] WB_SET,
    output logic [7:0]        WB_COUNT
);

`ifdef DIRTY_FLUSH_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WB, S_CLEAR, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WB, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SETS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [7:0]        wb_count;
    logic [7:0]        wb_count_nxt;
    logic              at_last;

    assign at_last  = (idx == LAST_IDX);
    assign RF_DIN   = 1'b0;
    assign WB_COUNT = wb_count;

    // State, set index and writeback counter registers
    always_ff @(posedge CLKA) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            idx      <= '0;
            wb_count <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            wb_count <= wb_count_nxt;
        end
    end

    // Next-state and output decode; advancing from the last set goes to DONE, never wraps
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        wb_count_nxt = wb_count;
        FLUSH_BUSY   = 1'b0;
        FLUSH_DONE   = 1'b0;
        RF_EN        = 1'b0;
        RF_WE        = 1'b0;
        RF_ADDR      = '0;
        WB_VALID     = 1'b0;
        WB_SET       = '0;
        case (state)
            S_IDLE: begin
                if (FLUSH_REQ) begin
                    state_nxt    = S_READ;
                    idx_nxt      = '0;
                    wb_count_nxt = '0;
                end
            end
            S_READ: begin
                FLUSH_BUSY = 1'b1;
                RF_EN      = 1'b1;
                RF_ADDR    = idx;
                if (RF_DOUT) begin
                    state_nxt = S_WB;
                end else if (at_last) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            S_WB: begin
                FLUSH_BUSY = 1'b1;
                WB_VALID   = 1'b1;
                WB_SET     = idx;
                if (WB_READY) begin
                    wb_count_nxt = wb_count + 8'd1;
`ifdef DIRTY_FLUSH_CLEAR_EN
                    state_nxt = S_CLEAR;
`else
                    if (at_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_READ;
                        idx_nxt   = idx + ADDR_W'(1);
                    end
`endif
                end
            end
`ifdef DIRTY_FLUSH_CLEAR_EN
            S_CLEAR: begin
                FLUSH_BUSY = 1'b1;
                RF_EN      = 1'b1;
                RF_WE      = 1'b1;
                RF_ADDR    = idx;
                if (at_last) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_READ;
                    idx_nxt   = idx + ADDR_W'(1);
                end
            end
`endif
            S_DONE: begin
                FLUSH_DONE = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dirty_flush_walker.sv
// tb/tb_dirty_flush_walker.sv - self-checking bench for dirty_flush_walker
module tb_dirty_flush_walker;

    localparam int N  = 128;
    localparam int AW = 7;
`ifdef DIRTY_FLUSH_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic          CLKA      = 1'b0;
    logic          RST_N     = 1'b0;
    logic          FLUSH_REQ = 1'b0;
    logic          WB_READY  = 1'b0;
    logic          FLUSH_BUSY, FLUSH_DONE, RF_EN, RF_WE, RF_DIN, RF_DOUT, WB_VALID;
    logic [AW-1:0] RF_ADDR, WB_SET;
    logic [7:0]    WB_COUNT;

    dirty_flush_walker #(.NUM_SETS(N), .ADDR_W(AW)) dut (
        .CLKA(CLKA), .RST_N(RST_N), .FLUSH_REQ(FLUSH_REQ),
        .FLUSH_BUSY(FLUSH_BUSY), .FLUSH_DONE(FLUSH_DONE),
        .RF_EN(RF_EN), .RF_WE(RF_WE), .RF_DIN(RF_DIN), .RF_ADDR(RF_ADDR), .RF_DOUT(RF_DOUT),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_SET(WB_SET), .WB_COUNT(WB_COUNT)
    );

    always #5 CLKA = ~CLKA;

    bit mem [N];
    int stall [N];
    int tcyc = 0;
    int t0 = 0;
    int n_pass = 0;
    int n_total = 0;

    int rd_q[$];
    int hs_q[$];
    int clr_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int proto_bad = 0;
    int wait_cnt = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_rstn = 1'b0;
    logic [AW-1:0] prev_set = '0;

    assign RF_DOUT = (RF_EN && !RF_WE) ? mem[RF_ADDR] : 1'b0;

    // regfile model and cycle counter
    always @(posedge CLKA) begin
        tcyc++;
        if (RF_EN && RF_WE) mem[RF_ADDR] = RF_DIN;
    end

    // ready driver with per-set stall and observation log
    always @(negedge CLKA) begin
        if (WB_VALID) begin
            WB_READY = (wait_cnt >= stall[WB_SET]);
            wait_cnt++;
        end else begin
            WB_READY = 1'b0;
            wait_cnt = 0;
        end
        if (!RF_EN && (RF_ADDR != 0 || RF_DIN != 0)) proto_bad++;
        if (RF_EN && RF_WE && RF_DIN != 0) proto_bad++;
        if (CLR == 0 && RF_WE) proto_bad++;
        if (FLUSH_BUSY !== (RF_EN | WB_VALID)) proto_bad++;
        if (FLUSH_DONE && FLUSH_BUSY) proto_bad++;
        if (prev_rstn && prev_valid && !prev_ready && (!WB_VALID || WB_SET != prev_set)) proto_bad++;
        if (RF_EN && !RF_WE) rd_q.push_back(int'(RF_ADDR));
        if (RF_EN && RF_WE) clr_q.push_back(int'(RF_ADDR));
        if (WB_VALID && WB_READY) hs_q.push_back(int'(WB_SET));
        if (FLUSH_DONE) begin
            done_cnt++;
            done_cyc = tcyc - t0;
        end
        prev_valid = WB_VALID;
        prev_ready = WB_READY;
        prev_set   = WB_SET;
        prev_rstn  = RST_N;
    end

    task automatic step();
        @(posedge CLKA);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({FLUSH_BUSY, FLUSH_DONE, RF_EN, RF_WE, RF_DIN, RF_ADDR, WB_VALID, WB_SET, WB_COUNT});
    endfunction

    // Expected behaviour comes from a snapshot of the dirty bits and the stall plan
    task automatic run_flush(input string tag, input bit pulse10);
        bit snap [N];
        int exp_hs[$];
        int exp_cyc;
        int guard;
        int bad;
        int left;
        snap = mem;
        exp_cyc = N + 1;
        for (int i = 0; i < N; i++) begin
            if (snap[i]) begin
                exp_hs.push_back(i);
                exp_cyc += stall[i] + 1 + CLR;
            end
        end
        rd_q.delete();
        hs_q.delete();
        clr_q.delete();
        done_cnt  = 0;
        proto_bad = 0;
        step();
        FLUSH_REQ = 1'b1;
        t0 = tcyc;
        step();
        FLUSH_REQ = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 20000) begin
            FLUSH_REQ = (pulse10 && RF_EN && !RF_WE && RF_ADDR == AW'(10)) ? 1'b1 : 1'b0;
            step();
            guard++;
        end
        FLUSH_REQ = 1'b0;
        repeat (8) step();
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_cyc, exp_cyc);
        check({tag, " wb_count"}, WB_COUNT, exp_hs.size());
        check({tag, " read_count"}, rd_q.size(), N);
        bad = 0;
        for (int i = 0; i < N; i++) if (i >= rd_q.size() || rd_q[i] != i) bad++;
        check({tag, " read_order_errors"}, bad, 0);
        check({tag, " wb_sets_count"}, hs_q.size(), exp_hs.size());
        bad = 0;
        for (int i = 0; i < exp_hs.size(); i++) if (i >= hs_q.size() || hs_q[i] != exp_hs[i]) bad++;
        check({tag, " wb_set_errors"}, bad, 0);
        check({tag, " clear_count"}, clr_q.size(), CLR * exp_hs.size());
        bad = 0;
        for (int i = 0; i < clr_q.size(); i++) if (i >= exp_hs.size() || clr_q[i] != exp_hs[i]) bad++;
        check({tag, " clear_addr_errors"}, bad, 0);
        left = 0;
        for (int i = 0; i < N; i++) if (mem[i]) left++;
        check({tag, " dirty_left"}, left, (CLR != 0) ? 0 : exp_hs.size());
        check({tag, " protocol_errors"}, proto_bad, 0);
        check({tag, " idle_busy"}, FLUSH_BUSY, 0);
    endtask

    initial begin
        int guard;
        int dens;
        for (int i = 0; i < N; i++) begin
            mem[i] = 1'b0;
            stall[i] = 0;
        end
        repeat (3) step();
        check("reset_outputs", outs(), 0);
        RST_N = 1'b1;
        step();

        run_flush("all_clean", 1'b0);

        mem[5] = 1'b1;
        run_flush("bit5", 1'b0);

        for (int i = 0; i < N; i++) mem[i] = 1'b0;
        mem[0] = 1'b1;
        mem[127] = 1'b1;
        stall[0] = 4;
        stall[127] = 4;
        run_flush("bits0_127_stall4", 1'b0);

        for (int i = 0; i < N; i++) begin
            mem[i] = 1'b1;
            stall[i] = 0;
        end
        run_flush("all_dirty", 1'b0);

        for (int i = 0; i < N; i++) mem[i] = 1'b0;
        mem[10] = 1'b1;
        mem[60] = 1'b1;
        run_flush("req_pulse_in_read", 1'b1);

        for (int i = 0; i < N; i++) mem[i] = 1'b0;
        mem[40] = 1'b1;
        stall[40] = 1000;
        step();
        FLUSH_REQ = 1'b1;
        step();
        FLUSH_REQ = 1'b0;
        guard = 0;
        while (!(WB_VALID && WB_SET == AW'(40)) && guard < 2000) begin
            step();
            guard++;
        end
        check("reached_wb40", {WB_VALID, 25'd0, WB_SET}, {1'b1, 25'd0, 7'd40});
        RST_N = 1'b0;
        step();
        check("reset_mid_wb_outputs", outs(), 0);
        check("reset_keeps_dirty40", mem[40], 1);
        RST_N = 1'b1;
        stall[40] = 0;
        step();
        run_flush("after_reset", 1'b0);

        for (int r = 0; r < 5; r++) begin
            dens = $urandom_range(0, 100);
            for (int i = 0; i < N; i++) begin
                mem[i] = ($urandom_range(0, 99) < dens);
                stall[i] = $urandom_range(0, 3);
            end
            run_flush($sformatf("random%0d", r), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dirty_flush_walker.md
DIRTY_FLUSH_WALKER -- requirements
Module: dirty_flush_walker

Interface
REQ-001 SHALL have parameter NUM_SETS, default 128, number of sets walked (2..128).
REQ-002 SHALL have parameter ADDR_W, default 7, set-index width.
REQ-003 SHALL have port CLKA  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port FLUSH_REQ  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port FLUSH_BUSY  output  1  high from first READ cycle through last CLEAR/WB cycle.
REQ-007 SHALL have port FLUSH_DONE  output  1  single-cycle completion pulse.
REQ-008 SHALL have port RF_EN / RF_WE / RF_DIN  output  1 each  dirty-bit regfile enable / write-enable / write data.
REQ-009 SHALL have port RF_ADDR  output  ADDR_W  dirty-bit regfile address.
REQ-010 SHALL have port RF_DOUT  input  1  dirty-bit regfile read data, combinational (valid the same cycle as RF_EN=1, RF_WE=0).
REQ-011 SHALL have port WB_VALID  output  1, WB_READY  input  1, WB_SET  output  ADDR_W  writeback request handshake.
REQ-012 SHALL have port WB_COUNT  output  8  number of writebacks accepted in the current/last flush.

Function
REQ-013 SHALL implement states IDLE, READ, WB, CLEAR, DONE with a set index register idx.
REQ-014 IDLE: RF_EN=0, WB_VALID=0; FLUSH_REQ=1 -> READ, idx=0, WB_COUNT=0.
REQ-015 READ: RF_EN=1, RF_WE=0, RF_ADDR=idx; RF_DOUT=1 -> WB with WB_SET=idx; RF_DOUT=0 -> advance.
REQ-016 Advance: idx==NUM_SETS-1 -> DONE, else idx=idx+1 and READ; idx SHALL never wrap past NUM_SETS-1.
REQ-017 WB: WB_VALID=1, WB_SET stable, RF_EN=0 until WB_READY=1 sampled; WB_VALID SHALL NOT drop before handshake.
REQ-018 On WB handshake WB_COUNT SHALL increment by 1 (max NUM_SETS, no overflow at 8 bits), then CLEAR (macro on) or advance (macro off).
REQ-019 CLEAR: exactly one cycle RF_EN=1, RF_WE=1, RF_DIN=0, RF_ADDR=idx, then advance.
REQ-020 DONE: FLUSH_DONE=1, FLUSH_BUSY=0 for one cycle, then IDLE.
REQ-021 FLUSH_REQ outside IDLE SHALL be ignored (not queued); FLUSH_REQ held high causes a new flush starting the cycle after DONE.
REQ-022 Latency: all-clean flush, REQ sampled at edge 0 -> READ cycles 1..NUM_SETS, FLUSH_DONE in cycle NUM_SETS+1; each dirty set adds (WB cycles) + 1 CLEAR cycle (macro on).
REQ-023 RF_ADDR, RF_DIN SHALL be 0 whenever RF_EN=0.

Reset
REQ-024 RST_N=0 at a rising edge SHALL force IDLE, idx=0, WB_COUNT=0, all outputs 0, regardless of state (including mid-WB with WB_VALID high).
REQ-025 Reset SHALL NOT modify regfile contents beyond any write already issued.

Configuration
REQ-026 Macro DIRTY_FLUSH_CLEAR_EN defined: CLEAR state present; each accepted writeback clears its dirty bit.
REQ-027 Macro undefined: CLEAR state absent; RF_WE SHALL be constantly 0; WB handshake advances directly.

Verification
REQ-028 All bits 0, NUM_SETS=128, FLUSH_REQ pulse at edge 0 -> 128 reads addr 0..127, FLUSH_DONE in cycle 129, WB_COUNT=0.
REQ-029 Bit 5 dirty, WB_READY=1 -> WB_SET=5 one cycle, CLEAR addr 5 DIN 0, DONE cycle 131 (macro on) / 130 (macro off), WB_COUNT=1.
REQ-030 Bits 0 and 127 dirty, WB_READY low 4 cycles each -> WB_VALID held stable 5 cycles each, WB_COUNT=2, bit 0/127 read 0 afterwards (macro on).
REQ-031 All 128 bits dirty, WB_READY=1 -> WB_COUNT=128 without overflow, FLUSH_DONE once.
REQ-032 RST_N low in WB at set 40 -> next cycle all outputs 0, IDLE; new FLUSH_REQ restarts at addr 0.
REQ-033 FLUSH_REQ pulsed during READ at set 10 -> ignored; exactly one FLUSH_DONE.
